// File: rtl/mux_key_lookup_pipe_if.sv
// Lookup-table bus: table write port, lookup request channel and result channel.
// master = table user (drives writes, requests, out_ready)
// slave  = lookup table (drives in_ready and the result fields)
interface mux_key_lookup_pipe_if #(
    parameter int unsigned NR_KEY   = 4,
    parameter int unsigned KEY_LEN  = 4,
    parameter int unsigned DATA_LEN = 8
);
    localparam int unsigned IW = $clog2(NR_KEY);

    logic                wr_en;
    logic [IW-1:0]       wr_idx;
    logic [KEY_LEN-1:0]  wr_key;
    logic [DATA_LEN-1:0] wr_data;
    logic                clr;
    logic                in_valid;
    logic                in_ready;
    logic [KEY_LEN-1:0]  in_key;
    logic [DATA_LEN-1:0] def_data;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_LEN-1:0] out_data;
    logic                out_hit;
    logic                out_multi;
    logic [IW-1:0]       out_idx;

    modport master (
        output wr_en, wr_idx, wr_key, wr_data, clr,
        output in_valid, in_key, def_data, out_ready,
        input  in_ready, out_valid, out_data, out_hit, out_multi, out_idx
    );

    modport slave (
        input  wr_en, wr_idx, wr_key, wr_data, clr,
        input  in_valid, in_key, def_data, out_ready,
        output in_ready, out_valid, out_data, out_hit, out_multi, out_idx
    );
endinterface

// File: rtl/mux_key_lookup_pipe.sv
// Programmable pipelined key->data lookup table with valid/ready handshake.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : slave side of mux_key_lookup_pipe_if (writes, clr, request, result)
// PIPE=1 splits the lookup into a match register (match vector + selected data)
// and a result register (hit/multi/idx/final data); PIPE=0 uses only the result
// register. in_ready is combinational from out_ready.
module mux_key_lookup_pipe #(
    parameter int unsigned NR_KEY      = 4,
    parameter int unsigned KEY_LEN     = 4,
    parameter int unsigned DATA_LEN    = 8,
    parameter bit          HAS_DEFAULT = 1'b1,
    parameter bit          PRIORITY    = 1'b1,
    parameter bit          PIPE        = 1'b1
) (
    input logic                  clk,
    input logic                  rst_n,
    mux_key_lookup_pipe_if.slave bus
);
    localparam int unsigned IW  = $clog2(NR_KEY);
    localparam int unsigned IWP = IW + 1;

    // Table storage
    logic [KEY_LEN-1:0]  key_q  [NR_KEY];
    logic [DATA_LEN-1:0] data_q [NR_KEY];
    logic [NR_KEY-1:0]   valid_q;
    logic                wr_ok;

    // Front end (current table state) and back end (input of result register)
    logic [NR_KEY-1:0]   match_c;
    logic [DATA_LEN-1:0] sel_c;
    logic                in_ready;
    logic                accept;
    logic                out_load;
    logic                be_valid;
    logic [NR_KEY-1:0]   be_match;
    logic [DATA_LEN-1:0] be_sel;
    logic [DATA_LEN-1:0] be_def;
    logic                fin_hit;
    logic                fin_multi;
    logic [IW-1:0]       fin_idx;
    logic [DATA_LEN-1:0] fin_data;

    // Result register
    logic                out_valid_q;
    logic [DATA_LEN-1:0] out_data_q;
    logic                out_hit_q;
    logic                out_multi_q;
    logic [IW-1:0]       out_idx_q;

    assign wr_ok    = bus.wr_en && ({1'b0, bus.wr_idx} < IWP'(NR_KEY));
    assign out_load = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    // Table write; clr beats a simultaneous write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < int'(NR_KEY); i++) begin
                key_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (bus.clr) begin
            valid_q <= '0;
        end else if (wr_ok) begin
            valid_q[bus.wr_idx] <= 1'b1;
            key_q[bus.wr_idx]   <= bus.wr_key;
            data_q[bus.wr_idx]  <= bus.wr_data;
        end
    end

    // Match vector and data selection against the pre-edge table contents
    always_comb begin
        match_c = '0;
        sel_c   = '0;
        for (int i = 0; i < int'(NR_KEY); i++) begin
            match_c[i] = valid_q[i] && (key_q[i] == bus.in_key);
        end
        if (PRIORITY) begin
            // Walk downward so the lowest matching entry is written last
            for (int i = int'(NR_KEY) - 1; i >= 0; i--) begin
                if (match_c[i]) sel_c = data_q[i];
            end
        end else begin
            for (int i = 0; i < int'(NR_KEY); i++) begin
                if (match_c[i]) sel_c = sel_c | data_q[i];
            end
        end
    end

    generate
        if (PIPE) begin : g_pipe
            logic                s0_valid_q;
            logic [NR_KEY-1:0]   s0_match_q;
            logic [DATA_LEN-1:0] s0_sel_q;
            logic [DATA_LEN-1:0] s0_def_q;

            // Match stage: holds one request; frees up when the result register loads
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s0_valid_q <= 1'b0;
                    s0_match_q <= '0;
                    s0_sel_q   <= '0;
                    s0_def_q   <= '0;
                end else if (accept) begin
                    s0_valid_q <= 1'b1;
                    s0_match_q <= match_c;
                    s0_sel_q   <= sel_c;
                    s0_def_q   <= bus.def_data;
                end else if (out_load) begin
                    s0_valid_q <= 1'b0;
                end
            end

            assign in_ready = !s0_valid_q || out_load;
            assign be_valid = s0_valid_q;
            assign be_match = s0_match_q;
            assign be_sel   = s0_sel_q;
            assign be_def   = s0_def_q;
        end else begin : g_flat
            assign in_ready = out_load;
            assign be_valid = accept;
            assign be_match = match_c;
            assign be_sel   = sel_c;
            assign be_def   = bus.def_data;
        end
    endgenerate

    // Hit/multi flags, lowest matching index and miss substitution
    always_comb begin
        fin_hit   = |be_match;
        fin_multi = |(be_match & (be_match - NR_KEY'(1)));
        fin_idx   = '0;
        for (int i = int'(NR_KEY) - 1; i >= 0; i--) begin
            if (be_match[i]) fin_idx = IW'(i);
        end
        if (fin_hit) begin
            fin_data = be_sel;
        end else if (HAS_DEFAULT) begin
            fin_data = be_def;
        end else begin
            fin_data = '0;
        end
    end

    // Result register; payload held while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_hit_q   <= 1'b0;
            out_multi_q <= 1'b0;
            out_idx_q   <= '0;
        end else if (out_load) begin
            out_valid_q <= be_valid;
            if (be_valid) begin
                out_data_q  <= fin_data;
                out_hit_q   <= fin_hit;
                out_multi_q <= fin_multi;
                out_idx_q   <= fin_idx;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_hit   = out_hit_q;
    assign bus.out_multi = out_multi_q;
    assign bus.out_idx   = out_idx_q;
endmodule

// File: tb/tb_mux_key_lookup_pipe.sv
// Bench for mux_key_lookup_pipe. Two instances share table writes and out_ready:
//   A: HAS_DEFAULT=1, PRIORITY=1, PIPE=1
//   B: HAS_DEFAULT=0, PRIORITY=0, PIPE=0
// Each instance has its own request channel and expected-result queue.
module tb_mux_key_lookup_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_key_lookup_pipe_if #(.NR_KEY(4), .KEY_LEN(4), .DATA_LEN(8)) if_a ();
    mux_key_lookup_pipe_if #(.NR_KEY(4), .KEY_LEN(4), .DATA_LEN(8)) if_b ();

    mux_key_lookup_pipe #(
        .NR_KEY(4), .KEY_LEN(4), .DATA_LEN(8),
        .HAS_DEFAULT(1'b1), .PRIORITY(1'b1), .PIPE(1'b1)
    ) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));

    mux_key_lookup_pipe #(
        .NR_KEY(4), .KEY_LEN(4), .DATA_LEN(8),
        .HAS_DEFAULT(1'b0), .PRIORITY(1'b0), .PIPE(1'b0)
    ) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    // Shared table-write and out_ready drive
    logic       wr_en = 1'b0;
    logic       clr = 1'b0;
    logic       out_ready = 1'b1;
    logic [1:0] wr_idx = '0;
    logic [3:0] wr_key = '0;
    logic [7:0] wr_data = '0;

    assign if_a.wr_en = wr_en;   assign if_b.wr_en = wr_en;
    assign if_a.clr = clr;       assign if_b.clr = clr;
    assign if_a.wr_idx = wr_idx; assign if_b.wr_idx = wr_idx;
    assign if_a.wr_key = wr_key; assign if_b.wr_key = wr_key;
    assign if_a.wr_data = wr_data; assign if_b.wr_data = wr_data;
    assign if_a.out_ready = out_ready; assign if_b.out_ready = out_ready;

    int n_checks = 0;
    int n_fail = 0;

    // Reference table
    logic [3:0] m_key  [4];
    logic [7:0] m_data [4];
    bit         m_val  [4];

    // Expected results {data, hit, multi, idx}
    logic [11:0] q_a[$];
    logic [11:0] q_b[$];

    // Operation descriptor consumed by run_ops
    int         req_n = 0;
    logic [3:0] req_key [8];
    logic [7:0] req_def [8];
    bit         op_wr = 1'b0;
    bit         op_clr = 1'b0;
    logic [1:0] op_idx = '0;
    logic [3:0] op_key = '0;
    logic [7:0] op_data = '0;
    bit         rdy_pat = 1'b0;
    int         last_cycles = 0;

    logic [11:0] out_a, out_b;
    assign out_a = {if_a.out_data, if_a.out_hit, if_a.out_multi, if_a.out_idx};
    assign out_b = {if_b.out_data, if_b.out_hit, if_b.out_multi, if_b.out_idx};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] model(input logic [3:0] k, input logic [7:0] def,
                                          input bit hd, input bit pr);
        logic [7:0] d = 8'h00;
        bit         hit = 1'b0;
        int         cnt = 0;
        logic [1:0] idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (m_val[i] && m_key[i] == k) begin
                cnt++;
                if (!hit) begin
                    idx = 2'(i);
                    d   = m_data[i];
                end else if (!pr) begin
                    d = d | m_data[i];
                end
                hit = 1'b1;
            end
        end
        if (!hit) d = hd ? def : 8'h00;
        return {d, hit, (cnt >= 2), idx};
    endfunction

    // Drives the pending write/clr on the first cycle and streams req_n lookups
    // into both instances; expectations are taken against the pre-edge table.
    task automatic run_ops();
        int pa = 0;
        int pb = 0;
        int cyc = 0;
        do begin
            @(negedge clk);
            out_ready = rdy_pat ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            wr_en   = (cyc == 0) && op_wr;
            clr     = (cyc == 0) && op_clr;
            wr_idx  = op_idx;
            wr_key  = op_key;
            wr_data = op_data;
            if_a.in_valid = (pa < req_n);
            if (pa < req_n) begin
                if_a.in_key   = req_key[pa];
                if_a.def_data = req_def[pa];
            end
            if_b.in_valid = (pb < req_n);
            if (pb < req_n) begin
                if_b.in_key   = req_key[pb];
                if_b.def_data = req_def[pb];
            end
            #1;
            if (if_a.in_valid && if_a.in_ready) begin
                q_a.push_back(model(if_a.in_key, if_a.def_data, 1'b1, 1'b1));
                pa++;
            end
            if (if_b.in_valid && if_b.in_ready) begin
                q_b.push_back(model(if_b.in_key, if_b.def_data, 1'b0, 1'b0));
                pb++;
            end
            if (cyc == 0) begin
                if (op_clr) begin
                    for (int i = 0; i < 4; i++) m_val[i] = 1'b0;
                end else if (op_wr) begin
                    m_val[op_idx]  = 1'b1;
                    m_key[op_idx]  = op_key;
                    m_data[op_idx] = op_data;
                end
            end
            cyc++;
        end while ((pa < req_n || pb < req_n) && cyc < 200);
        check("ops_accepted", 32'(pa + pb), 32'(2 * req_n));
        last_cycles = cyc;
        @(negedge clk);
        if_a.in_valid = 1'b0;
        if_b.in_valid = 1'b0;
        wr_en = 1'b0;
        clr = 1'b0;
        out_ready = 1'b1;
        op_wr = 1'b0;
        op_clr = 1'b0;
        req_n = 0;
    endtask

    task automatic write_entry(input logic [1:0] idx, input logic [3:0] k, input logic [7:0] d);
        op_wr = 1'b1; op_idx = idx; op_key = k; op_data = d; req_n = 0;
        run_ops();
    endtask

    task automatic lookup(input logic [3:0] k, input logic [7:0] def);
        req_n = 1; req_key[0] = k; req_def[0] = def;
        run_ops();
    endtask

    task automatic drain();
        int t = 0;
        out_ready = 1'b1;
        while ((q_a.size() != 0 || q_b.size() != 0) && t < 50) begin
            @(negedge clk);
            #2;
            t++;
        end
        check("drain_pending", 32'(q_a.size() + q_b.size()), 32'd0);
    endtask

    // Result monitors: compare on handshake, check hold while stalled
    bit          stall_a = 1'b0, stall_b = 1'b0;
    logic [11:0] prev_a = '0, prev_b = '0;

    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            stall_a = 1'b0;
        end else begin
            if (stall_a) check("stall_hold_a", 32'({if_a.out_valid, out_a}), 32'({1'b1, prev_a}));
            if (if_a.out_valid && out_ready) begin
                if (q_a.size() == 0) check("unexpected_a", 32'(q_a.size()), 32'd1);
                else check("result_a", 32'(out_a), 32'(q_a.pop_front()));
            end
            stall_a = if_a.out_valid && !out_ready;
            prev_a  = out_a;
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            stall_b = 1'b0;
        end else begin
            if (stall_b) check("stall_hold_b", 32'({if_b.out_valid, out_b}), 32'({1'b1, prev_b}));
            if (if_b.out_valid && out_ready) begin
                if (q_b.size() == 0) check("unexpected_b", 32'(q_b.size()), 32'd1);
                else check("result_b", 32'(out_b), 32'(q_b.pop_front()));
            end
            stall_b = if_b.out_valid && !out_ready;
            prev_b  = out_b;
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_val[i] = 1'b0; m_key[i] = '0; m_data[i] = '0;
        end
        if_a.in_valid = 1'b0; if_a.in_key = '0; if_a.def_data = '0;
        if_b.in_valid = 1'b0; if_b.in_key = '0; if_b.def_data = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid_a", 32'(if_a.out_valid), 32'd0);
        check("rst_out_a", 32'(out_a), 32'd0);
        check("rst_valid_b", 32'(if_b.out_valid), 32'd0);
        check("rst_out_b", 32'(out_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic hit and latency
        write_entry(2'd0, 4'd3, 8'h11);
        write_entry(2'd1, 4'd5, 8'h22);
        lookup(4'd5, 8'h00);
        #1;
        check("latency_b_1", 32'(if_b.out_valid), 32'd1);
        check("latency_a_1", 32'(if_a.out_valid), 32'd0);
        @(negedge clk);
        #1;
        check("latency_a_2", 32'(if_a.out_valid), 32'd1);
        drain();

        // Miss with default
        lookup(4'd9, 8'hEE);
        drain();

        // Duplicate keys: priority vs OR
        write_entry(2'd0, 4'd7, 8'h0F);
        write_entry(2'd2, 4'd7, 8'hF0);
        lookup(4'd7, 8'h00);
        drain();

        // Same-cycle write is invisible to the lookup accepted on that edge
        op_clr = 1'b1; req_n = 0;
        run_ops();
        op_wr = 1'b1; op_idx = 2'd1; op_key = 4'd4; op_data = 8'h44;
        req_n = 1; req_key[0] = 4'd4; req_def[0] = 8'h5A;
        run_ops();
        lookup(4'd4, 8'h5A);
        drain();

        // clr together with wr_en: clr wins
        op_clr = 1'b1; op_wr = 1'b1; op_idx = 2'd3; op_key = 4'd6; op_data = 8'h66;
        req_n = 0;
        run_ops();
        lookup(4'd6, 8'h61);
        lookup(4'd4, 8'h62);
        drain();

        // Streams: full rate, then with out_ready toggling
        write_entry(2'd0, 4'd1, 8'hA1);
        write_entry(2'd1, 4'd2, 8'hB2);
        write_entry(2'd2, 4'd3, 8'hC3);
        write_entry(2'd3, 4'd2, 8'hD4);
        begin
            logic [3:0] keys [8];
            keys = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd2, 4'd1, 4'hF, 4'd3};
            for (int i = 0; i < 8; i++) begin
                req_key[i] = keys[i];
                req_def[i] = 8'(8'h50 + i);
            end
            req_n = 8; rdy_pat = 1'b0;
            run_ops();
            check("full_rate_cycles", 32'(last_cycles), 32'd8);
            drain();
            for (int i = 0; i < 8; i++) begin
                req_key[i] = keys[7 - i];
                req_def[i] = 8'(8'h80 + i);
            end
            req_n = 8; rdy_pat = 1'b1;
            run_ops();
            rdy_pat = 1'b0;
            drain();
        end

        // Reset with two lookups in flight
        req_n = 2; req_key[0] = 4'd1; req_def[0] = 8'h01; req_key[1] = 4'd2; req_def[1] = 8'h02;
        run_ops();
        rst_n = 1'b0;
        #1;
        check("inflight_rst_valid_a", 32'(if_a.out_valid), 32'd0);
        check("inflight_rst_valid_b", 32'(if_b.out_valid), 32'd0);
        check("inflight_rst_out_a", 32'(out_a), 32'd0);
        q_a.delete();
        q_b.delete();
        for (int i = 0; i < 4; i++) m_val[i] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lookup(4'd1, 8'h77);
        lookup(4'd3, 8'h78);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
